// File: rtl/tft_8080_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tft_8080_frame_writer
// Brief    : One-time panel init, then per-frame window + memory-write command
//            and an RGB565 pixel stream over an 8080 parallel bus.
// Revision : 1.0 - initial release
// ============================================================================
module tft_8080_frame_writer #(
    parameter int H_ACT    = 256,
    parameter int V_ACT    = 128,
    parameter int WR_LOW   = 1,
    parameter int FIFO_AW  = 4,
    parameter int RST_HOLD = 24000,
    parameter int RST_WAIT = 120000,
    parameter int SLP_WAIT = 120000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFRAME_START,
    input  logic        iPIX_VALID,
    input  logic [15:0] iPIX_DATA,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic        lcd_reset,
    output logic [15:0] lcd_data,
    output logic        oINIT_DONE,
    output logic        oFRAME_DONE,
    output logic        oOVERFLOW
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam int               WCW       = $clog2(WR_LOW + 1);
    localparam logic [WCW-1:0]   WR_LOAD   = WCW'(WR_LOW);
    localparam logic [WCW-1:0]   WR_ONE    = WCW'(1);
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [31:0]      HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0]      WAIT_LAST = 32'(RST_WAIT - 1);
    localparam logic [31:0]      SLP_END   = 32'(WR_LOW + SLP_WAIT);
    localparam logic [31:0]      TOTAL     = 32'(H_ACT) * 32'(V_ACT);
    localparam logic [15:0]      H_LAST    = 16'(H_ACT - 1);
    localparam logic [15:0]      V_LAST    = 16'(V_ACT - 1);

    typedef enum logic [2:0] {
        RST_HOLD_S = 3'd0,
        RST_WAIT_S = 3'd1,
        INIT_S     = 3'd2,
        IDLE_S     = 3'd3,
        WIN_S      = 3'd4,
        STREAM_S   = 3'd5,
        DONE_S     = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [31:0]        dly_cnt;
    logic [31:0]        pix_cnt;
    logic [3:0]         idx;
    logic [WCW-1:0]     wr_cnt;
    logic               bus_ready;
    logic               abort_pend;
    logic               start_pend;
    logic               abort_req;

    logic               wr_go;
    logic [16:0]        go_word;
    logic               dly_clr;
    logic               idx_inc;
    logic               idx_clr;
    logic               pix_inc;
    logic               flush;
    logic               pop;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW:0]   wptr;
    logic [FIFO_AW:0]   rptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_req;
    logic               push;

    // {rs, data} for the 11-word column/page window and memory-write command
    function automatic logic [16:0] win_word(input logic [3:0] i);
        case (i)
            4'd0:    win_word = {1'b0, 16'h002A};
            4'd3:    win_word = {1'b1, 8'h00, H_LAST[15:8]};
            4'd4:    win_word = {1'b1, 8'h00, H_LAST[7:0]};
            4'd5:    win_word = {1'b0, 16'h002B};
            4'd8:    win_word = {1'b1, 8'h00, V_LAST[15:8]};
            4'd9:    win_word = {1'b1, 8'h00, V_LAST[7:0]};
            4'd10:   win_word = {1'b0, 16'h002C};
            default: win_word = {1'b1, 16'h0000};
        endcase
    endfunction

    assign bus_ready  = (wr_cnt == '0);
    assign abort_req  = abort_pend || iFRAME_START;
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                        (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign push_req   = iPIX_VALID && (state == WIN_S || state == STREAM_S);
    assign push       = push_req && (!fifo_full || pop) && !flush;
    assign lcd_rd     = 1'b1;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= RST_HOLD_S;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_go    = 1'b0;
        go_word  = 17'h0;
        dly_clr  = 1'b0;
        idx_inc  = 1'b0;
        idx_clr  = 1'b0;
        pix_inc  = 1'b0;
        flush    = 1'b0;
        pop      = 1'b0;
        case (state)
            RST_HOLD_S: begin
                if (dly_cnt == HOLD_LAST) begin
                    state_nx = RST_WAIT_S;
                    dly_clr  = 1'b1;
                end
            end
            RST_WAIT_S: begin
                if (dly_cnt == WAIT_LAST) begin
                    state_nx = INIT_S;
                    dly_clr  = 1'b1;
                    idx_clr  = 1'b1;
                end
            end
            INIT_S: begin
                if (bus_ready) begin
                    case (idx)
                        4'd0: begin wr_go = 1'b1; go_word = {1'b0, 16'h0011}; idx_inc = 1'b1; end
                        // dly_cnt restarted when the sleep-out write began
                        4'd1: if (dly_cnt == SLP_END) idx_inc = 1'b1;
                        4'd2: begin wr_go = 1'b1; go_word = {1'b0, 16'h003A}; idx_inc = 1'b1; end
                        4'd3: begin wr_go = 1'b1; go_word = {1'b1, 16'h0055}; idx_inc = 1'b1; end
                        4'd4: begin wr_go = 1'b1; go_word = {1'b0, 16'h0029}; idx_inc = 1'b1; end
                        default: state_nx = IDLE_S;
                    endcase
                end
            end
            IDLE_S: begin
                if (iFRAME_START || start_pend) begin
                    state_nx = WIN_S;
                    flush    = 1'b1;
                    idx_clr  = 1'b1;
                end
            end
            WIN_S, STREAM_S: begin
                if (bus_ready) begin
                    if (abort_req) begin
                        state_nx = WIN_S;
                        flush    = 1'b1;
                        idx_clr  = 1'b1;
                    end else if (state == WIN_S) begin
                        if (idx == 4'd11) begin
                            state_nx = STREAM_S;
                        end else begin
                            wr_go   = 1'b1;
                            go_word = win_word(idx);
                            idx_inc = 1'b1;
                        end
                    end else if (pix_cnt == TOTAL) begin
                        state_nx = DONE_S;
                    end else if (!fifo_empty) begin
                        wr_go   = 1'b1;
                        go_word = {1'b1, mem[rptr[FIFO_AW-1:0]]};
                        pop     = 1'b1;
                        pix_inc = 1'b1;
                    end
                end
            end
            DONE_S:  state_nx = IDLE_S;
            default: state_nx = RST_HOLD_S;
        endcase
    end

    // Bus write engine: WR low for WR_LOW cycles, then one high cycle
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            lcd_cs   <= 1'b1;
            lcd_rs   <= 1'b1;
            lcd_wr   <= 1'b1;
            lcd_data <= 16'h0000;
            wr_cnt   <= '0;
        end else if (wr_go) begin
            lcd_cs   <= 1'b0;
            lcd_rs   <= go_word[16];
            lcd_data <= go_word[15:0];
            lcd_wr   <= 1'b0;
            wr_cnt   <= WR_LOAD;
        end else if (wr_cnt != '0) begin
            wr_cnt <= wr_cnt - WR_ONE;
            if (wr_cnt == WR_ONE) lcd_wr <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dly_cnt <= 32'd0;
            idx     <= 4'd0;
            pix_cnt <= 32'd0;
        end else begin
            if (dly_clr || wr_go) dly_cnt <= 32'd0;
            else                  dly_cnt <= dly_cnt + 32'd1;
            if (idx_clr)      idx <= 4'd0;
            else if (idx_inc) idx <= idx + 4'd1;
            if (flush)        pix_cnt <= 32'd0;
            else if (pix_inc) pix_cnt <= pix_cnt + 32'd1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            lcd_reset   <= 1'b0;
            oINIT_DONE  <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oOVERFLOW   <= 1'b0;
            abort_pend  <= 1'b0;
            start_pend  <= 1'b0;
        end else begin
            lcd_reset   <= (state_nx != RST_HOLD_S);
            oFRAME_DONE <= (state_nx == DONE_S);
            if (state == INIT_S && state_nx == IDLE_S) oINIT_DONE <= 1'b1;
            if (flush)                                     oOVERFLOW <= 1'b0;
            else if (push_req && fifo_full && !pop)        oOVERFLOW <= 1'b1;
            if (flush) abort_pend <= 1'b0;
            else if (iFRAME_START && (state == WIN_S || state == STREAM_S)) abort_pend <= 1'b1;
            // a start seen in DONE_S is held for the IDLE_S cycle that follows
            if (flush) start_pend <= 1'b0;
            else if (iFRAME_START && state == DONE_S) start_pend <= 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) mem[wptr[FIFO_AW-1:0]] <= iPIX_DATA;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tft_8080_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_8080_frame_writer
// Brief    : Two instances (small stream frame; large window with tiny FIFO)
//            checked against a word-list model of the expected bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_8080_frame_writer;

    localparam int WRL_A = 1;
    localparam int WRL_B = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs [2];
    logic        pv [2];
    logic [15:0] pd [2];
    logic        cs [2];
    logic        rs [2];
    logic        wr [2];
    logic        rd [2];
    logic        lreset [2];
    logic [15:0] d [2];
    logic        idone [2];
    logic        fdone [2];
    logic        ovf [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] cap_a [$];
    logic [16:0] cap_b [$];
    logic [16:0] ref_q [$];
    logic [15:0] pushed [$];
    int          lowlen [2];
    logic        pwr [2];
    int          fd_cnt [2];

    always #5 clk = ~clk;

    tft_8080_frame_writer #(
        .H_ACT(4), .V_ACT(2), .WR_LOW(WRL_A), .FIFO_AW(4),
        .RST_HOLD(4), .RST_WAIT(8), .SLP_WAIT(8)
    ) u_dut_a (
        .iCLK(clk), .iRST(rst_n), .iFRAME_START(fs[0]), .iPIX_VALID(pv[0]), .iPIX_DATA(pd[0]),
        .lcd_cs(cs[0]), .lcd_rs(rs[0]), .lcd_wr(wr[0]), .lcd_rd(rd[0]), .lcd_reset(lreset[0]),
        .lcd_data(d[0]), .oINIT_DONE(idone[0]), .oFRAME_DONE(fdone[0]), .oOVERFLOW(ovf[0])
    );

    tft_8080_frame_writer #(
        .H_ACT(256), .V_ACT(128), .WR_LOW(WRL_B), .FIFO_AW(2),
        .RST_HOLD(4), .RST_WAIT(8), .SLP_WAIT(8)
    ) u_dut_b (
        .iCLK(clk), .iRST(rst_n), .iFRAME_START(fs[1]), .iPIX_VALID(pv[1]), .iPIX_DATA(pd[1]),
        .lcd_cs(cs[1]), .lcd_rs(rs[1]), .lcd_wr(wr[1]), .lcd_rd(rd[1]), .lcd_reset(lreset[1]),
        .lcd_data(d[1]), .oINIT_DONE(idone[1]), .oFRAME_DONE(fdone[1]), .oOVERFLOW(ovf[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each bus write is captured on its WR rising edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                pwr[i]    <= 1'b1;
                lowlen[i] <= 0;
            end else begin
                if (!wr[i]) begin
                    lowlen[i] <= lowlen[i] + 1;
                end else if (!pwr[i]) begin
                    if (i == 0) cap_a.push_back({rs[0], d[0]});
                    else        cap_b.push_back({rs[1], d[1]});
                    check("wr_low_width", lowlen[i], (i == 0) ? WRL_A : WRL_B);
                    lowlen[i] <= 0;
                end
                pwr[i] <= wr[i];
                if (fdone[i]) fd_cnt[i] <= fd_cnt[i] + 1;
            end
        end
    end

    task automatic ref_init();
        ref_q.push_back({1'b0, 16'h0011});
        ref_q.push_back({1'b0, 16'h003A});
        ref_q.push_back({1'b1, 16'h0055});
        ref_q.push_back({1'b0, 16'h0029});
    endtask

    task automatic ref_window(input int h, input int v);
        int dims [2];
        dims[0] = h - 1;
        dims[1] = v - 1;
        for (int k = 0; k < 2; k++) begin
            ref_q.push_back({1'b0, (k == 0) ? 16'h002A : 16'h002B});
            ref_q.push_back({1'b1, 16'h0000});
            ref_q.push_back({1'b1, 16'h0000});
            ref_q.push_back({1'b1, 16'(dims[k] / 256)});
            ref_q.push_back({1'b1, 16'(dims[k] % 256)});
        end
        ref_q.push_back({1'b0, 16'h002C});
    endtask

    task automatic cmp_list(input int i, input int off, input string tag);
        int          sz;
        logic [16:0] got;
        sz = (i == 0) ? cap_a.size() : cap_b.size();
        check({tag, "_len"}, sz, off + ref_q.size());
        for (int k = 0; k < ref_q.size(); k++) begin
            got = 17'h1FFFF;
            if (off + k < sz) got = (i == 0) ? cap_a[off + k] : cap_b[off + k];
            check(tag, got, ref_q[k]);
        end
    endtask

    task automatic wait_cap(input int i, input int n, input string tag);
        int t;
        t = 0;
        while (((i == 0) ? cap_a.size() : cap_b.size()) < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, (((i == 0) ? cap_a.size() : cap_b.size()) >= n), 1);
    endtask

    task automatic wait_idone(input int i, input string tag);
        int t;
        t = 0;
        while (!idone[i] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, idone[i], 1'b1);
    endtask

    task automatic pulse_fs(input int i);
        @(negedge clk);
        fs[i] = 1'b1;
        @(negedge clk);
        fs[i] = 1'b0;
    endtask

    task automatic push_spaced(input int i, input logic [15:0] v);
        @(negedge clk);
        pv[i] = 1'b1;
        pd[i] = v;
        @(negedge clk);
        pv[i] = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          base;
        int          j;
        int          found;
        logic [15:0] px;
        logic [16:0] w;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fs[i] = 1'b0;
            pv[i] = 1'b0;
            pd[i] = 16'h0;
            fd_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_cs", cs[0], 1'b1);
        check("rst_rs", rs[0], 1'b1);
        check("rst_wr", wr[0], 1'b1);
        check("rst_rd", rd[0], 1'b1);
        check("rst_lcd_reset", lreset[0], 1'b0);
        check("rst_data", d[0], 16'h0);
        check("rst_flags", {idone[0], fdone[0], ovf[0]}, 3'b000);
        check("rst_all_b", {cs[1], rs[1], wr[1], rd[1], lreset[1], d[1], idone[1], fdone[1], ovf[1]},
              {4'b1111, 1'b0, 16'h0, 3'b000});

        // ---------------- power-up timing and init ROM ----------------
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (lreset[0] == 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("rst_hold_cycles", n, 4);
        n = 0;
        while (wr[0] == 1'b1 && n < 200) begin
            if (lreset[0]) n++;
            @(negedge clk);
        end
        check("rst_wait_cycles_in_range", (n >= 8 && n <= 10), 1);
        check("cs_low_at_first_cmd", cs[0], 1'b0);
        fs[0] = 1'b1;
        @(negedge clk);
        fs[0] = 1'b0;
        wait_idone(0, "init_done_a");
        check("init_done_after_29", cap_a.size(), 4);
        ref_q.delete();
        ref_init();
        cmp_list(0, 0, "init_seq_a");
        repeat (30) @(negedge clk);
        check("early_start_ignored", cap_a.size(), 4);
        wait_idone(1, "init_done_b");
        cmp_list(1, 0, "init_seq_b");

        // ---------------- window for 256x128 ----------------
        pulse_fs(1);
        wait_cap(1, 15, "win_b_timeout");
        ref_q.delete();
        ref_window(256, 128);
        cmp_list(1, 4, "win_b");

        // ---------------- overflow with 4-entry FIFO, WR_LOW=3 ----------------
        repeat (2) @(negedge clk);
        pushed.delete();
        for (int k = 0; k < 10; k++) begin
            px = 16'($urandom);
            pushed.push_back(px);
            pv[1] = 1'b1;
            pd[1] = px;
            @(negedge clk);
        end
        pv[1] = 1'b0;
        repeat (80) @(negedge clk);
        check("ovf_set", ovf[1], 1'b1);
        n = cap_b.size() - 15;
        check("ovf_some_dropped", (n >= 4 && n < 10), 1);
        check("ovf_first_pixel", cap_b[15], {1'b1, pushed[0]});
        j = 0;
        for (int k = 15; k < cap_b.size(); k++) begin
            w = cap_b[k];
            found = 0;
            while (j < pushed.size() && found == 0) begin
                if (w == {1'b1, pushed[j]}) found = 1;
                j++;
            end
            check("ovf_arrival_order", found, 1);
        end
        base = cap_b.size();
        pulse_fs(1);
        repeat (3) @(negedge clk);
        check("ovf_cleared_by_start", ovf[1], 1'b0);
        wait_cap(1, base + 11, "win_b_restart_timeout");
        ref_q.delete();
        ref_window(256, 128);
        cmp_list(1, base, "win_b_restart");

        // ---------------- full 4x2 frame ----------------
        base = cap_a.size();
        pulse_fs(0);
        repeat (3) @(negedge clk);
        ref_q.delete();
        ref_window(4, 2);
        for (int k = 0; k < 8; k++) begin
            px = 16'($urandom);
            ref_q.push_back({1'b1, px});
            push_spaced(0, px);
        end
        n = 0;
        while (!fdone[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_seen", fdone[0], 1'b1);
        fs[0] = 1'b1;                       // start arrives while in DONE_S
        @(negedge clk);
        fs[0] = 1'b0;
        cmp_list(0, base, "frame_a");
        check("frame_done_single_pulse", fd_cnt[0], 1);
        check("no_ovf_a", ovf[0], 1'b0);

        // start taken from DONE_S -> fresh window
        base = cap_a.size();
        wait_cap(0, base + 11, "win_after_done_timeout");
        ref_q.delete();
        ref_window(4, 2);
        cmp_list(0, base, "win_after_done");

        // ---------------- abort after 3 of 8 pixels ----------------
        base = cap_a.size();
        ref_q.delete();
        for (int k = 0; k < 3; k++) begin
            px = 16'($urandom);
            ref_q.push_back({1'b1, px});
            push_spaced(0, px);
        end
        wait_cap(0, base + 3, "abort_prefix_timeout");
        pulse_fs(0);
        repeat (3) @(negedge clk);
        ref_window(4, 2);
        for (int k = 0; k < 8; k++) begin
            px = 16'($urandom);
            ref_q.push_back({1'b1, px});
            push_spaced(0, px);
        end
        check("no_done_for_aborted", fd_cnt[0], 1);
        n = 0;
        while (!fdone[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_after_abort", fdone[0], 1'b1);
        repeat (2) @(negedge clk);
        cmp_list(0, base, "abort_frame_a");
        check("frame_done_count", fd_cnt[0], 2);

        // ---------------- reset in the middle of streaming ----------------
        push_spaced(1, 16'h1234);
        push_spaced(1, 16'h5678);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check("async_rst_outputs",
                  {cs[i], rs[i], wr[i], rd[i], lreset[i], d[i], idone[i], fdone[i], ovf[i]},
                  {4'b1111, 1'b0, 16'h0, 3'b000});
        repeat (3) @(negedge clk);
        base = cap_b.size();
        n = cap_a.size();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idone(1, "reinit_done_b");
        wait_idone(0, "reinit_done_a");
        ref_q.delete();
        ref_init();
        cmp_list(1, base, "reinit_seq_b");
        cmp_list(0, n, "reinit_seq_a");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
